// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The helpers work on 32-bit values, so any WIDTH up to 32 can use them.
package clkdiv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] DIV_MIN = 32'd2;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

  // Number of high cycles per period; always at least one high and one low cycle.
  function automatic logic [31:0] high_time(input logic [31:0] div, input logic [31:0] hi);
    if (hi == 32'd0)
      return 32'd1;
    if (hi > div - 32'd1)
      return div - 32'd1;
    return hi;
  endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Control/status bundle of the programmable clock divider.
// Defining CLKDIV_DUTY_EN adds the hi_i high-time input.
interface clkdiv_if #(
  parameter int WIDTH = 16
);

  logic             en;
  logic [WIDTH-1:0] div_i;
  logic             div_load;
`ifdef CLKDIV_DUTY_EN
  logic [WIDTH-1:0] hi_i;
`endif
  logic             dclk;
  logic             tick;
  logic             running;
  logic [WIDTH-1:0] div_cur;

`ifdef CLKDIV_DUTY_EN
  modport master (output en, div_i, div_load, hi_i, input dclk, tick, running, div_cur);
  modport slave  (input en, div_i, div_load, hi_i, output dclk, tick, running, div_cur);
`else
  modport master (output en, div_i, div_load, input dclk, tick, running, div_cur);
  modport slave  (input en, div_i, div_load, output dclk, tick, running, div_cur);
`endif

endinterface

// File: rtl/clkdiv_shadow.sv
// Pending divisor (and high time, with CLKDIV_DUTY_EN) for the next period.
// The selected value bypasses the register when a load lands on the boundary cycle.
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_new,
`ifdef CLKDIV_DUTY_EN
  input  logic [WIDTH-1:0] hi_new,
  output logic [WIDTH-1:0] hi_sel,
`endif
  output logic [WIDTH-1:0] div_sel
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] div_clamped;

  assign div_clamped = WIDTH'(clamp_div(32'(div_new)));

  always_ff @(posedge clk) begin
    if (clr)
      div_pend <= DIV_RST;
    else if (load)
      div_pend <= div_clamped;
  end

  assign div_sel = load ? div_clamped : div_pend;

`ifdef CLKDIV_DUTY_EN
  localparam logic [WIDTH-1:0] HI_RST = WIDTH'(DEFAULT_DIV / 2);

  logic [WIDTH-1:0] hi_pend;

  // High time is clamped against the divisor only when it is used.
  always_ff @(posedge clk) begin
    if (clr)
      hi_pend <= HI_RST;
    else if (load)
      hi_pend <= hi_new;
  end

  assign hi_sel = load ? hi_new : hi_pend;
`endif

endmodule

// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider producing a registered dclk and a tick enable.
// Optional macro CLKDIV_DUTY_EN adds a programmable high time (hi_i).
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic     clk,
  input  logic     clr,
  clkdiv_if.slave  bus
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] div_nx;
  logic [WIDTH-1:0] div_sel;
  logic [WIDTH-1:0] high;
  logic             dclk;
  logic             dclk_nx;
  logic             tick;
  logic             tick_nx;
  logic             running;
  logic             wrap;

`ifdef CLKDIV_DUTY_EN
  localparam logic [WIDTH-1:0] HI_RST = WIDTH'(DEFAULT_DIV / 2);

  logic [WIDTH-1:0] hi_cur;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] hi_sel;
`endif

  clkdiv_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) shadow (
    .clk     (clk),
    .clr     (clr),
    .load    (bus.div_load),
    .div_new (bus.div_i),
`ifdef CLKDIV_DUTY_EN
    .hi_new  (bus.hi_i),
    .hi_sel  (hi_sel),
`endif
    .div_sel (div_sel)
  );

  assign wrap = (cnt == div_cur - WIDTH'(1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div_cur;
    tick_nx  = 1'b0;
`ifdef CLKDIV_DUTY_EN
    hi_nx    = hi_cur;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.en) begin
          state_nx = RUN;
          div_nx   = div_sel;
          tick_nx  = 1'b1;
`ifdef CLKDIV_DUTY_EN
          hi_nx    = hi_sel;
`endif
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_nx = '0;
          if (bus.en) begin
            div_nx  = div_sel;
            tick_nx = 1'b1;
`ifdef CLKDIV_DUTY_EN
            hi_nx   = hi_sel;
`endif
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + WIDTH'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // dclk is computed from the next counter/divisor so the output register is glitch-free.
`ifdef CLKDIV_DUTY_EN
  assign high = WIDTH'(high_time(32'(div_nx), 32'(hi_nx)));
`else
  assign high = WIDTH'(high_time(32'(div_nx), 32'(div_nx >> 1)));
`endif

  assign dclk_nx = (state_nx == RUN) && (cnt_nx < high);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      div_cur <= DIV_RST;
      dclk    <= 1'b0;
      tick    <= 1'b0;
      running <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      hi_cur  <= HI_RST;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_cur <= div_nx;
      dclk    <= dclk_nx;
      tick    <= tick_nx;
      running <= (state_nx == RUN);
`ifdef CLKDIV_DUTY_EN
      hi_cur  <= hi_nx;
`endif
    end
  end

  assign bus.dclk    = dclk;
  assign bus.tick    = tick;
  assign bus.running = running;
  assign bus.div_cur = div_cur;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed self-checking bench for clkdiv_prog (WIDTH=16, DEFAULT_DIV=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clkdiv_prog;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  clkdiv_if #(.WIDTH(16)) bus ();

  clkdiv_prog #(
    .WIDTH       (16),
    .DEFAULT_DIV (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] d);
    bus.en       = e;
    bus.div_load = ld;
    bus.div_i    = d;
`ifdef CLKDIV_DUTY_EN
    bus.hi_i     = d >> 1;
`endif
  endtask

  task automatic checkOutput(input string tag, input logic ed, input logic et,
                             input logic er, input logic [15:0] ediv);
    total++;
    assert (bus.dclk === ed) else begin
      bad++;
      $error("[TB] FAIL %s dclk got=%0b exp=%0b", tag, bus.dclk, ed);
    end
    total++;
    assert (bus.tick === et) else begin
      bad++;
      $error("[TB] FAIL %s tick got=%0b exp=%0b", tag, bus.tick, et);
    end
    total++;
    assert (bus.running === er) else begin
      bad++;
      $error("[TB] FAIL %s running got=%0b exp=%0b", tag, bus.running, er);
    end
    total++;
    assert (bus.div_cur === ediv) else begin
      bad++;
      $error("[TB] FAIL %s div_cur got=%0d exp=%0d", tag, bus.div_cur, ediv);
    end
  endtask

  // Checks n running cycles starting at counter position start of a period p with h high cycles.
  task automatic checkRun(input string tag, input int start, input int n,
                          input int p, input int h, input int d);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (start + i) % p;
      checkOutput(tag, (c < h), (c == 0), 1'b1, 16'(d));
      @(negedge clk);
    end
  endtask

  task automatic checkIdle(input string tag, input int n, input int d);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, 1'b0, 1'b0, 1'b0, 16'(d));
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 16'd4);

    $display("[TB] start at default divisor");
    clr = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'd0);
    @(negedge clk);
    checkRun("div4", 0, 8, 4, 2, 4);

    $display("[TB] mid-period reload to 6");
    checkRun("mid4", 0, 1, 4, 2, 4);
    applyStimulus(1'b1, 1'b1, 16'd6);
    checkRun("mid4", 1, 1, 4, 2, 4);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("mid4", 2, 2, 4, 2, 4);
    checkRun("div6", 0, 12, 6, 3, 6);

    $display("[TB] wrap-cycle reload to 5");
    checkRun("pre5", 0, 5, 6, 3, 6);
    applyStimulus(1'b1, 1'b1, 16'd5);
    checkRun("wrap6", 5, 1, 6, 3, 6);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("div5", 0, 10, 5, 2, 5);

    $display("[TB] clamp of zero divisor");
    applyStimulus(1'b1, 1'b1, 16'd0);
    checkRun("pre2", 0, 1, 5, 2, 5);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("pre2", 1, 4, 5, 2, 5);
    checkRun("div2", 0, 6, 2, 1, 2);

    $display("[TB] stop and restart");
    applyStimulus(1'b1, 1'b1, 16'd4);
    checkRun("to4", 0, 1, 2, 1, 2);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("to4", 1, 1, 2, 1, 2);
    checkRun("stop4", 0, 1, 4, 2, 4);
    applyStimulus(1'b0, 1'b0, 16'd0);
    checkRun("stop4", 1, 3, 4, 2, 4);
    checkIdle("idle", 5, 4);
    applyStimulus(1'b1, 1'b0, 16'd0);
    @(negedge clk);
    checkRun("restart", 0, 8, 4, 2, 4);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 16'd6);
    checkRun("to6", 0, 1, 4, 2, 4);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("to6", 1, 3, 4, 2, 4);
    checkRun("pend8", 0, 1, 6, 3, 6);
    applyStimulus(1'b1, 1'b1, 16'd8);
    checkRun("pend8", 1, 1, 6, 3, 6);
    applyStimulus(1'b1, 1'b0, 16'd0);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid", 1'b0, 1'b0, 1'b0, 16'd4);
    clr = 1'b0;
    @(negedge clk);
    checkRun("after_rst", 0, 8, 4, 2, 4);

    $display("[TB] maximum divisor");
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    checkRun("tomax", 0, 1, 4, 2, 4);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("tomax", 1, 3, 4, 2, 4);
    checkRun("divmax", 0, 32770, 65535, 32767, 65535);
    applyStimulus(1'b0, 1'b0, 16'd0);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("rst_max", 1'b0, 1'b0, 1'b0, 16'd4);

    $display("[TB] load coinciding with start");
    clr = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'd3);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("div3", 0, 6, 3, 1, 3);

`ifdef CLKDIV_DUTY_EN
    $display("[TB] programmable high time");
    applyStimulus(1'b1, 1'b1, 16'd8);
    bus.hi_i = 16'd3;
    checkRun("to8h3", 0, 1, 3, 1, 3);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("to8h3", 1, 2, 3, 1, 3);
    checkRun("div8h3", 0, 16, 8, 3, 8);
    applyStimulus(1'b1, 1'b1, 16'd8);
    bus.hi_i = 16'd0;
    checkRun("toh0", 0, 1, 8, 3, 8);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("toh0", 1, 7, 8, 3, 8);
    checkRun("div8h0", 0, 8, 8, 1, 8);
    applyStimulus(1'b1, 1'b1, 16'd8);
    bus.hi_i = 16'd9;
    checkRun("toh9", 0, 1, 8, 1, 8);
    applyStimulus(1'b1, 1'b0, 16'd0);
    checkRun("toh9", 1, 7, 8, 1, 8);
    checkRun("div8h9", 0, 16, 8, 7, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
